// File: rtl/frequency_regulator_param.sv
// frequency_regulator_param
// Closed-loop divider regulator. Measures the high width of a synchronised
// feedback pulse and nudges a saturating divider value toward the width that
// matches the programmed set period, with a deadband around it.
module frequency_regulator_param #(
  parameter int               CNT_W    = 8,
  parameter int               DIV_W    = 8,
  parameter logic [DIV_W-1:0] DIV_INIT = 8'hB0,
  parameter logic [DIV_W-1:0] STEP     = 1,
  parameter logic [DIV_W-1:0] MIN_DIV  = 1,
  parameter logic [DIV_W-1:0] MAX_DIV  = 8'hFF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_psi,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_set_period,
  input  logic [CNT_W-1:0] i_deadband,
  input  logic             i_div_load,
  input  logic [DIV_W-1:0] i_div_load_val,
  output logic [DIV_W-1:0] o_adjusted_div,
  output logic             o_adj_valid,
  output logic             o_inc,
  output logic             o_dec,
  output logic             o_at_limit,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_duration
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_EVAL    = 2'd2,
    S_UPDATE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W:0]   MIN_X   = {1'b0, MIN_DIV};
  localparam logic [DIV_W:0]   MAX_X   = {1'b0, MAX_DIV};
  localparam logic [DIV_W:0]   STEP_X  = {1'b0, STEP};

  state_t r_state;
  state_t w_state_next;

  logic             r_psi_meta;
  logic             r_psi_s;
  logic             r_psi_d;
  logic [1:0]       r_settle;
  logic             r_armed;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic [DIV_W-1:0] r_div;
  logic             r_adj_valid;
  logic             r_inc;
  logic             r_dec;
  logic             r_overflow;
  logic [CNT_W-1:0] r_duration;

  logic             w_rise;
  logic             w_fall;
  logic [CNT_W:0]   w_hi_lim;
  logic [CNT_W:0]   w_lo_sum;
  logic             w_want_dec;
  logic             w_want_inc;
  logic [DIV_W:0]   w_div_up;
  logic [DIV_W-1:0] w_div_inc;
  logic [DIV_W-1:0] w_div_dec;
  logic [DIV_W-1:0] w_load_clamped;
  logic             w_eval_ok;
  logic             w_update_ok;

  // Two-flop synchroniser for psi plus a delayed copy for edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_psi_meta <= 1'b0;
      r_psi_s    <= 1'b0;
      r_psi_d    <= 1'b0;
    end else begin
      r_psi_meta <= i_psi;
      r_psi_s    <= r_psi_meta;
      r_psi_d    <= r_psi_s;
    end
  end

  // Arm rise detection only after the synchroniser holds real data and psi_s
  // has been seen low, so a pulse already high at reset release is skipped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_settle <= 2'd0;
      r_armed  <= 1'b0;
    end else begin
      if (r_settle != 2'd2) begin
        r_settle <= r_settle + 2'd1;
      end
      if (r_settle == 2'd2 && !r_psi_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_rise = r_armed & r_psi_s & ~r_psi_d;
  assign w_fall = ~r_psi_s & r_psi_d;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; dropping enable abandons whatever is in flight
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_rise) w_state_next = S_MEASURE;
      S_MEASURE: if (w_fall) w_state_next = S_EVAL;
      S_EVAL:    w_state_next = S_UPDATE;
      S_UPDATE:  w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
    if (!i_en) begin
      w_state_next = S_IDLE;
    end
  end

  // Pulse-width counter; the rise cycle counts as the first high cycle.
  // ovf marks a pulse that outlasted the counter range.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_en) begin
      if (r_state == S_IDLE && w_rise) begin
        r_count <= CNT_ONE;
        r_ovf   <= 1'b0;
      end else if (r_state == S_MEASURE && !w_fall && r_psi_s) begin
        if (r_count == CNT_MAX) begin
          r_ovf <= 1'b1;
        end else begin
          r_count <= r_count + CNT_ONE;
        end
      end
    end
  end

  // Decision, one bit wider than the operands so sums cannot wrap
  always_comb begin
    w_hi_lim   = {1'b0, i_set_period} + {1'b0, i_deadband};
    w_lo_sum   = {1'b0, r_count} + {1'b0, i_deadband};
    w_want_dec = ({1'b0, r_count} > w_hi_lim) | r_ovf;
    w_want_inc = ~w_want_dec & (w_lo_sum < {1'b0, i_set_period});
  end

  // Saturating step and clamped preset, one bit wider than the divider
  always_comb begin
    w_div_up  = {1'b0, r_div} + STEP_X;
    w_div_inc = (w_div_up > MAX_X) ? MAX_DIV : w_div_up[DIV_W-1:0];
    w_div_dec = ({1'b0, r_div} < (MIN_X + STEP_X)) ? MIN_DIV : (r_div - STEP);
    if (i_div_load_val < MIN_DIV) begin
      w_load_clamped = MIN_DIV;
    end else if (i_div_load_val > MAX_DIV) begin
      w_load_clamped = MAX_DIV;
    end else begin
      w_load_clamped = i_div_load_val;
    end
  end

  assign w_eval_ok   = (r_state == S_EVAL) & i_en;
  assign w_update_ok = (r_state == S_UPDATE) & i_en;

  // Latch the measurement and the decision; held until the next evaluation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_duration <= '0;
      r_overflow <= 1'b0;
      r_inc      <= 1'b0;
      r_dec      <= 1'b0;
    end else if (w_eval_ok) begin
      r_duration <= r_count;
      r_overflow <= r_ovf;
      r_inc      <= w_want_inc;
      r_dec      <= w_want_dec;
    end
  end

  // Divider update; an explicit load overrides the step but the
  // evaluation is still reported through adj_valid
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div       <= DIV_INIT;
      r_adj_valid <= 1'b0;
    end else begin
      r_adj_valid <= w_update_ok;
      if (i_div_load) begin
        r_div <= w_load_clamped;
      end else if (w_update_ok) begin
        if (r_inc) begin
          r_div <= w_div_inc;
        end else if (r_dec) begin
          r_div <= w_div_dec;
        end
      end
    end
  end

  assign o_adjusted_div = r_div;
  assign o_adj_valid    = r_adj_valid;
  assign o_inc          = r_inc;
  assign o_dec          = r_dec;
  assign o_overflow     = r_overflow;
  assign o_duration     = r_duration;
  assign o_at_limit     = (r_div == MIN_DIV) | (r_div == MAX_DIV);

endmodule

// File: doc/frequency_regulator_param.md
Name: frequency_regulator_param

Overview:
Parametrised closed-loop divider regulator. Synchronises the psi feedback pulse and measures how many cycles it stays high. On each falling edge it compares that width against a programmable set period with a deadband, then steps a saturating divider value up, down, or holds it. Sits between the pulse-feedback source and the programmable clock divider; supersedes the fixed 4-bit regulator.

Parameters:
CNT_W, 8, width of duration counter, set_period and deadband
DIV_W, 8, width of divider value
DIV_INIT, 8'hB0, adjusted_div value after reset
STEP, 1, divider increment/decrement per evaluation
MIN_DIV, 1, lower saturation bound (MIN_DIV <= DIV_INIT <= MAX_DIV)
MAX_DIV, 8'hFF, upper saturation bound

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
psi  in  1  asynchronous feedback pulse
en  in  1  regulation enable
set_period  in  CNT_W  target high width, cycles
deadband  in  CNT_W  tolerance, cycles
div_load  in  1  load div_load_val into divider
div_load_val  in  DIV_W  divider preset
adjusted_div  out  DIV_W  current divider value
adj_valid  out  1  one-cycle pulse per completed evaluation
inc  out  1  last evaluation incremented (held until next evaluation)
dec  out  1  last evaluation decremented (held)
at_limit  out  1  adjusted_div equals MIN_DIV or MAX_DIV
overflow  out  1  last measured pulse saturated counter (held)
duration  out  CNT_W  last completed pulse width

Behaviour:
- Reset (rst=0, async): adjusted_div=DIV_INIT; all other outputs 0; sync flops 0; state IDLE.
- psi passes through a 2-flop synchroniser to give psi_s, plus a delayed copy psi_d. rise = psi_s & ~psi_d; fall = ~psi_s & psi_d.
- FSM states:
  - IDLE: on rise with en=1, count=1, go to MEASURE.
  - MEASURE: each cycle psi_s=1, count increments, saturating at 2^CNT_W-1, which sets an internal ovf bit. On fall, go to EVAL.
  - EVAL (one cycle): duration<=count; overflow<=ovf; decide. Go to UPDATE.
  - UPDATE (one cycle): apply the step, pulse adj_valid, return to IDLE.
- A rise occurring in EVAL or UPDATE is ignored; that pulse is not measured.
- Decision is computed in CNT_W+1 bits, so there is no wrap:
  - count > set_period+deadband, or ovf=1: dec=1, inc=0.
  - count+deadband < set_period: inc=1, dec=0.
  - otherwise: inc=0, dec=0 (hold).
- Update is computed in DIV_W+1 bits:
  - inc: adjusted_div = min(adjusted_div+STEP, MAX_DIV).
  - dec: adjusted_div = max(adjusted_div-STEP, MIN_DIV), with no underflow.
- Latency: adjusted_div and adj_valid change on the 2nd clk edge after the edge at which fall is detected on psi_s.
- div_load: the value is clamped to [MIN_DIV, MAX_DIV] and written next edge. It has priority over an UPDATE in the same cycle; that update is dropped, but adj_valid still pulses.
- en=0: FSM forced to IDLE next edge and any in-flight measurement is discarded. adjusted_div holds; div_load still works.
- at_limit is combinational from adjusted_div.
- Reset mid-pulse: all state is cleared. The remaining high time of that pulse is not measured, because no rise is seen until psi_s goes low then high.

Test Plan:
- Reset: rst=0 with psi toggling -> adjusted_div=8'hB0; adj_valid, inc, dec, overflow, duration all 0; no update until a full pulse completes after release.
- Defaults, set_period=20, deadband=2, psi_s high 30 cycles -> duration=30, dec=1, adjusted_div=8'hAF, adj_valid high exactly one cycle, 2 edges after fall.
- psi_s high 10 cycles -> inc=1, adjusted_div=8'hB1. Then 21 and 18 cycles -> inc=dec=0, adjusted_div unchanged, adj_valid still pulses each time.
- div_load_val=8'hFF, then a 5-cycle pulse -> adjusted_div stays 8'hFF, at_limit=1. With MIN_DIV=1 and div_load_val=0 -> adjusted_div=1 (clamped); a long pulse keeps it at 1.
- psi_s high 300 cycles with CNT_W=8 -> duration=255, overflow=1, dec=1. div_load asserted in the UPDATE cycle -> load value wins.
- Mid-operation: en dropped, or rst pulsed low, midway through a 40-cycle pulse -> no adj_valid, adjusted_div unchanged (or DIV_INIT after rst). The next complete pulse is evaluated normally.
